// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the priority encoder / arbiter.
// Imported by the find-first-set sub-module and the top level.
package prio_enc_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Increment with wrap to zero at n; valid for any n, power of 2 or not.
    function automatic int wrap_inc(input int value, input int n);
        return (value + 1 >= n) ? 0 : value + 1;
    endfunction

endpackage

// File: rtl/prio_enc_ffs.sv
// Combinational find-first-set over N request bits.
// Fixed mode searches down from N-1; round-robin searches up from start.
module prio_enc_ffs
    import prio_enc_pkg::*;
#(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    input  logic         mode,
    output logic         found,
    output logic [W-1:0] sel
);

    localparam logic [W:0] NW = (W+1)'(N);

    logic [2*N-1:0] rot;
    logic [W-1:0]   fix_sel;
    logic [W-1:0]   off;
    logic [W:0]     sum;

    // Downward search: the first set bit met from the top wins.
    always_comb begin
        fix_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) fix_sel = W'(i);
        end
    end

    // Rotate so that bit 'start' lands at position 0, then take the lowest.
    always_comb begin
        rot = {req, req} >> start;
        off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) off = W'(k);
        end
    end

    // Map the rotated offset back to an absolute index, modulo N.
    always_comb begin
        sum = {1'b0, start} + {1'b0, off};
        found = |req;
        if (mode == MODE_FIXED) begin
            sel = fix_sel;
        end else if (sum >= NW) begin
            sel = W'(sum - NW);
        end else begin
            sel = W'(sum);
        end
    end

endmodule

// File: rtl/prio_enc_arb.sv
// N-input priority encoder / arbiter, fixed or round-robin priority,
// with a registered result and valid/ready back-pressure.
module prio_enc_arb
    import prio_enc_pkg::*;
#(
    parameter int N            = 8,
    parameter int W            = $clog2(N),
    parameter int RR_RESET_PTR = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_n,
    input  logic         mode,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] idx,
    output logic [N-1:0] grant,
    output logic [W-1:0] ptr
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic         load;
    logic         accept;
    logic [W-1:0] ptr_nxt;
    logic         found;
    logic [W-1:0] sel;

    assign load   = !out_valid || out_ready;
    assign accept = out_valid && out_ready;

    // Pointer after this edge; the search already uses it so a
    // back-to-back round-robin grant skips the index just accepted.
    always_comb begin
        ptr_nxt = ptr;
        if (accept && mode == MODE_RR) begin
            ptr_nxt = W'(wrap_inc(int'(idx), N));
        end
    end

    prio_enc_ffs #(
        .N(N),
        .W(W)
    ) u_ffs (
        .req  (req),
        .start(ptr_nxt),
        .mode (mode),
        .found(found),
        .sel  (sel)
    );

    // Result register, handshake and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            idx       <= '0;
            grant     <= '0;
            ptr       <= W'(RR_RESET_PTR);
        end else begin
            ptr <= ptr_nxt;
            if (load) begin
                if (!en_n && found) begin
                    out_valid <= 1'b1;
                    idx       <= sel;
                    grant     <= ONE << sel;
                end else begin
                    out_valid <= 1'b0;
                    idx       <= '0;
                    grant     <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_prio_enc_arb.sv
// Directed bench for prio_enc_arb: N=8 instance plus an N=5 instance
// for non-power-of-2 round-robin wrap.
module tb_prio_enc_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_n;
    logic       mode;
    logic       out_ready;
    logic [7:0] req;
    logic [4:0] req5;

    logic       v8;
    logic [2:0] idx8;
    logic [7:0] g8;
    logic [2:0] p8;
    logic       v5;
    logic [2:0] idx5;
    logic [4:0] g5;
    logic [2:0] p5;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    prio_enc_arb #(.N(8), .RR_RESET_PTR(0)) dut8 (
        .clk(clk), .rst_n(rst_n), .en_n(en_n), .mode(mode),
        .req(req), .out_ready(out_ready), .out_valid(v8),
        .idx(idx8), .grant(g8), .ptr(p8)
    );

    prio_enc_arb #(.N(5), .RR_RESET_PTR(0)) dut5 (
        .clk(clk), .rst_n(rst_n), .en_n(en_n), .mode(mode),
        .req(req5), .out_ready(out_ready), .out_valid(v5),
        .idx(idx5), .grant(g5), .ptr(p5)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic v,
                        input logic [2:0] i, input logic [7:0] g);
        chk({tag, ".valid"}, 64'(v8), 64'(v));
        chk({tag, ".idx"}, 64'(idx8), 64'(i));
        chk({tag, ".grant"}, 64'(g8), 64'(g));
    endtask

    initial begin
        rst_n = 1'b0; en_n = 1'b1; mode = 1'b0; out_ready = 1'b1;
        req = 8'h00; req5 = 5'h00;
        #1;
        chk8("reset", 1'b0, 3'd0, 8'h00);
        chk("reset.ptr", 64'(p8), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Fixed priority, back-to-back
        en_n = 1'b0; req = 8'b0010_1010; tick;
        chk8("fix0", 1'b1, 3'd5, 8'h20);
        req = 8'b1101_0010; tick;
        chk8("fix1", 1'b1, 3'd7, 8'h80);
        req = 8'hFF; tick;
        chk8("fix2", 1'b1, 3'd7, 8'h80);
        req = 8'b0001_0111; tick;
        chk8("fix3", 1'b1, 3'd4, 8'h10);

        // Disabled and empty
        en_n = 1'b1; req = 8'hFF; tick;
        chk8("dis0", 1'b0, 3'd0, 8'h00);
        tick;
        chk8("dis1", 1'b0, 3'd0, 8'h00);
        en_n = 1'b0; req = 8'h00; tick;
        chk8("empty", 1'b0, 3'd0, 8'h00);

        // Back-pressure
        req = 8'b0010_0000; tick;
        chk8("bp_cap", 1'b1, 3'd5, 8'h20);
        out_ready = 1'b0; req = 8'h01;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk8("bp_hold", 1'b1, 3'd5, 8'h20);
        end
        out_ready = 1'b1; tick;
        chk8("bp_rel", 1'b1, 3'd0, 8'h01);
        chk("fix.ptr", 64'(p8), 64'd0);

        // Drain, then round-robin fairness from ptr=0
        en_n = 1'b1; tick;
        chk8("drain", 1'b0, 3'd0, 8'h00);
        en_n = 1'b0; mode = 1'b1; req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            tick;
            chk8("rr", 1'b1, 3'(i % 8), 8'h01 << (i % 8));
            chk("rr.ptr", 64'(p8), 64'(i % 8));
        end

        // Round-robin wrap around a sparse request
        req = 8'b0000_0100; tick;
        chk8("rrw0", 1'b1, 3'd2, 8'h04);
        chk("rrw0.ptr", 64'(p8), 64'd1);
        req = 8'b0010_0100; tick;
        chk8("rrw1", 1'b1, 3'd5, 8'h20);
        chk("rrw1.ptr", 64'(p8), 64'd3);
        tick;
        chk8("rrw2", 1'b1, 3'd2, 8'h04);
        chk("rrw2.ptr", 64'(p8), 64'd6);
        tick;
        chk8("rrw3", 1'b1, 3'd5, 8'h20);
        chk("rrw3.ptr", 64'(p8), 64'd3);

        // N=5 wrap from ptr=0; the N=8 unit accepts idx 5 and idles
        req = 8'h00; req5 = 5'b10001; tick;
        chk("n5a.idx", 64'(idx5), 64'd0);
        chk("n5a.grant", 64'(g5), 64'h01);
        chk("n5a.ptr", 64'(p5), 64'd0);
        chk("n8idle.ptr", 64'(p8), 64'd6);
        tick;
        chk("n5b.idx", 64'(idx5), 64'd4);
        chk("n5b.grant", 64'(g5), 64'h10);
        chk("n5b.ptr", 64'(p5), 64'd1);
        tick;
        chk("n5c.idx", 64'(idx5), 64'd0);
        chk("n5c.ptr", 64'(p5), 64'd0);
        chk("n5c.valid", 64'(v5), 64'd1);
        req5 = 5'h00;

        // Async reset while holding a round-robin result with ptr=6
        req = 8'b0100_0000; tick;
        chk8("pre_rst", 1'b1, 3'd6, 8'h40);
        chk("pre_rst.ptr", 64'(p8), 64'd6);
        out_ready = 1'b0; tick;
        chk8("pre_rst_hold", 1'b1, 3'd6, 8'h40);
        #2 rst_n = 1'b0;
        #1;
        chk8("async_rst", 1'b0, 3'd0, 8'h00);
        chk("async_rst.ptr", 64'(p8), 64'd0);
        chk("async_rst.v5", 64'(v5), 64'd0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1; req = 8'hFF;
        #1;
        chk8("post_rst", 1'b0, 3'd0, 8'h00);
        tick;
        chk8("post_rst1", 1'b1, 3'd0, 8'h01);
        chk("post_rst1.ptr", 64'(p8), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
